// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared definitions for the operand fetch controller.
// Holds the memory command codes, the ALU op encodings and the FSM state encoding.
// Ports: none (package).
package operand_fetch_ctrl_pkg;

  // Command codes on the tx bus; sized to CMD_W at the point of use.
  localparam int CMD_CLEAR = 0;
  localparam int CMD_LOAD  = 1;
  localparam int CMD_HOLD  = 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_REQ_A,
    ST_WAIT_A,
    ST_REQ_B,
    ST_WAIT_B,
    ST_EXEC,
    ST_DONE,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/operand_fetch_ctrl_fetch_alu.sv
// Combinational two-operand ALU producing a WIDTH+1 bit result.
// Ports: a, b (operands), op (ALU op), y (result; top bit is carry for add,
//        borrow for sub, zero for and/or).
module fetch_alu
  import operand_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH:0]   y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = {1'b0, a} + {1'b0, b};
      // Zero-extended subtraction wraps so the top bit is set exactly when a < b.
      OP_SUB:  y = {1'b0, a} - {1'b0, b};
      OP_AND:  y = {1'b0, a & b};
      default: y = {1'b0, a | b};
    endcase
  end

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: issues CLEAR/LOAD/HOLD to the operand memory, fetches
// A then B while checking the memory phase bit, resyncs on mismatch, then runs the ALU.
// Ports: clock, reset (async active-high), start/op/clear (requests, IDLE only),
//        entrada/contador (memory data and phase), tx (registered command),
//        busy, done (1-cycle pulse), result, err (mismatch seen), fault (retries exhausted).
module operand_fetch_ctrl
  import operand_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CMD_W     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             clear,
  input  logic [WIDTH-1:0] entrada,
  input  logic             contador,
  output logic [CMD_W-1:0] tx,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             err,
  output logic             fault
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [RW-1:0]    retry_q;
  logic [WIDTH:0]   alu_y;
  logic [CMD_W-1:0] tx_d;
  logic             busy_d, done_d;
  logic             accept, cap_a, cap_b, mismatch;

  fetch_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cap_a    = 1'b0;
    cap_b    = 1'b0;
    mismatch = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // clear has priority; a simultaneous start is dropped, not queued.
        if (clear) begin
          state_d = ST_CLR;
        end else if (start) begin
          state_d = ST_REQ_A;
          accept  = 1'b1;
        end
      end
      ST_CLR:    state_d = ST_IDLE;
      ST_REQ_A:  state_d = ST_WAIT_A;
      ST_WAIT_A: begin
        if (contador) begin
          cap_a   = 1'b1;
          state_d = ST_REQ_B;
        end else begin
          mismatch = 1'b1;
        end
      end
      ST_REQ_B:  state_d = ST_WAIT_B;
      ST_WAIT_B: begin
        if (!contador) begin
          cap_b   = 1'b1;
          state_d = ST_EXEC;
        end else begin
          mismatch = 1'b1;
        end
      end
      ST_EXEC:   state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase

    // Restarting from A issues one extra LOAD, which flips the memory's phase back into step.
    if (mismatch) state_d = (retry_q == RETRY_LIMIT) ? ST_FAULT : ST_REQ_A;

    // Outputs are registered from the next state so they line up with the state they describe.
    tx_d = CMD_W'(CMD_HOLD);
    if (state_d == ST_REQ_A || state_d == ST_REQ_B) tx_d = CMD_W'(CMD_LOAD);
    else if (state_d == ST_CLR)                     tx_d = CMD_W'(CMD_CLEAR);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_CLR);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx      <= CMD_W'(CMD_HOLD);
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      fault   <= 1'b0;
      result  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      retry_q <= '0;
    end else begin
      tx   <= tx_d;
      busy <= busy_d;
      done <= done_d;
      if (accept) begin
        op_q    <= op;
        err     <= 1'b0;
        retry_q <= '0;
      end
      if (cap_a) a_q <= entrada;
      if (cap_b) b_q <= entrada;
      if (mismatch) begin
        err <= 1'b1;
        if (retry_q == RETRY_LIMIT) fault   <= 1'b1;
        else                        retry_q <= retry_q + 1'b1;
      end
      if (state_q == ST_EXEC) result <= alu_y;
    end
  end

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
module tb_operand_fetch_ctrl;
  import operand_fetch_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int CMD_W = 4;

  logic             clock = 1'b0;
  logic             reset, start, clear, contador;
  logic [1:0]       op;
  logic [WIDTH-1:0] entrada;
  logic [CMD_W-1:0] tx;
  logic             busy, done, err, fault;
  logic [WIDTH:0]   result;

  always #5 clock = ~clock;

  operand_fetch_ctrl #(.WIDTH(WIDTH), .CMD_W(CMD_W), .MAX_RETRY(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .clear    (clear),
    .entrada  (entrada),
    .contador (contador),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .err      (err),
    .fault    (fault)
  );

  // Operand memory model: each LOAD alternately returns n1 (contador=1) and n2 (contador=0).
  logic [WIDTH-1:0] mem_n1, mem_n2;
  logic [WIDTH-1:0] mem_q = '0;
  logic             mem_cnt = 1'b0;
  logic             mem_phase = 1'b0;
  logic             stuck0, preset_req, preset_val;

  always @(posedge clock) begin
    if (preset_req) begin
      mem_phase <= preset_val;
    end else if (tx == CMD_W'(CMD_LOAD)) begin
      if (!mem_phase) begin
        mem_q <= mem_n1; mem_cnt <= 1'b1; mem_phase <= 1'b1;
      end else begin
        mem_q <= mem_n2; mem_cnt <= 1'b0; mem_phase <= 1'b0;
      end
    end else if (tx == CMD_W'(CMD_CLEAR)) begin
      mem_q <= '0; mem_cnt <= 1'b0; mem_phase <= 1'b0;
    end
  end

  assign entrada  = mem_q;
  assign contador = stuck0 ? 1'b0 : mem_cnt;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: expected {result, err} pushed when a start is driven, popped on done.
  typedef struct packed {
    logic [WIDTH:0] res;
    logic           err;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clock) begin
    exp_t e;
    if (!reset && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result %0d with no pending operation", result);
      end else begin
        e = sb_q.pop_front();
        check("sb_result", result, e.res);
        check("sb_err", err, e.err);
      end
    end
  end

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] n1;
    logic [WIDTH-1:0] n2;
    logic             ph;
    logic [WIDTH:0]   res;
    logic             err;
    int               lat;
  } vec_t;
  vec_t vecs[8];

  task automatic push_exp(input logic [WIDTH:0] r, input logic e);
    exp_t x;
    x.res = r;
    x.err = e;
    sb_q.push_back(x);
  endtask

  task automatic preset_phase(input logic ph);
    @(negedge clock); preset_req = 1'b1; preset_val = ph;
    @(negedge clock); preset_req = 1'b0;
  endtask

  // Waits up to 40 cycles for done; returns the number of cycles waited or -1.
  task automatic wait_done(input string tag, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin n = i; break; end
    end
    if (n < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done within 40 cycles", tag);
    end
  endtask

  task automatic run_op(input vec_t v, input bit do_preset, input string tag);
    int n;
    mem_n1 = v.n1;
    mem_n2 = v.n2;
    if (do_preset) preset_phase(v.ph);
    @(negedge clock);
    op = v.op; start = 1'b1;
    push_exp(v.res, v.err);
    @(negedge clock);
    start = 1'b0;
    // First three command cycles are LOAD, HOLD, LOAD whether or not a resync follows.
    check({tag, "_busy"}, busy, 1);
    check({tag, "_tx0"}, tx, CMD_LOAD);
    @(negedge clock);
    check({tag, "_tx1"}, tx, CMD_HOLD);
    @(negedge clock);
    check({tag, "_tx2"}, tx, CMD_LOAD);
    wait_done(tag, n);
    if (n >= 0) check({tag, "_latency"}, n + 2, v.lat);
    @(negedge clock);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; clear = 1'b0; op = 2'b00;
    stuck0 = 1'b0; preset_req = 1'b0; preset_val = 1'b0;
    mem_n1 = '0; mem_n2 = '0;

    //             op     n1     n2     ph    result     err   latency
    vecs[0] = '{2'b00, 4'd5,  4'd3,  1'b0, 5'b01000, 1'b0, 5};
    vecs[1] = '{2'b01, 4'd5,  4'd3,  1'b1, 5'b00010, 1'b1, 7};
    vecs[2] = '{2'b10, 4'd5,  4'd3,  1'b0, 5'b00001, 1'b0, 5};
    vecs[3] = '{2'b11, 4'd5,  4'd3,  1'b0, 5'b00111, 1'b0, 5};
    vecs[4] = '{2'b01, 4'd3,  4'd5,  1'b0, 5'b11110, 1'b0, 5};
    vecs[5] = '{2'b00, 4'd15, 4'd1,  1'b0, 5'b10000, 1'b0, 5};
    vecs[6] = '{2'b00, 4'd9,  4'd8,  1'b1, 5'b10001, 1'b1, 7};
    vecs[7] = '{2'b10, 4'd12, 4'd10, 1'b0, 5'b01000, 1'b0, 5};

    repeat (2) @(negedge clock);
    check("rst_tx", tx, CMD_HOLD);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_fault", fault, 0);
    check("rst_result", result, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_op(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Contador stuck low: three mismatches, then fault with start/clear ignored.
    preset_phase(1'b0);
    stuck0 = 1'b1;
    @(negedge clock); op = 2'b00; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (5) @(negedge clock);
    check("flt_before", fault, 0);
    @(negedge clock);
    check("flt_set", fault, 1);
    check("flt_busy", busy, 1);
    check("flt_tx", tx, CMD_HOLD);
    check("flt_err", err, 1);
    start = 1'b1; clear = 1'b1;
    repeat (4) @(negedge clock);
    start = 1'b0; clear = 1'b0;
    check("flt_hold_fault", fault, 1);
    check("flt_hold_tx", tx, CMD_HOLD);
    check("flt_hold_busy", busy, 1);
    reset = 1'b1; #1;
    check("flt_rst_fault", fault, 0);
    check("flt_rst_busy", busy, 0);
    @(negedge clock); reset = 1'b0; stuck0 = 1'b0;

    // clear and start together: one CLEAR, no LOAD, never busy.
    @(negedge clock); clear = 1'b1; start = 1'b1; op = 2'b00;
    @(negedge clock); clear = 1'b0; start = 1'b0;
    check("clr_tx", tx, CMD_CLEAR);
    check("clr_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("clr_after_tx", tx, CMD_HOLD);
      check("clr_after_busy", busy, 0);
    end

    // Reset asserted while waiting for B; memory phase is left as the fetch left it.
    mem_n1 = 4'd5; mem_n2 = 4'd3;
    preset_phase(1'b0);
    @(negedge clock); op = 2'b00; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_busy", busy, 1);
    reset = 1'b1; #1;
    check("mid_rst_tx", tx, CMD_HOLD);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_done", done, 0);
    @(negedge clock); reset = 1'b0;
    run_op('{2'b00, 4'd5, 4'd3, 1'b0, 5'b01000, 1'b0, 5}, 1'b0, "post_rst");

    // start held high: back-to-back ops with one IDLE cycle between dones.
    mem_n1 = 4'd5; mem_n2 = 4'd3;
    preset_phase(1'b0);
    @(negedge clock); op = 2'b10; start = 1'b1;
    push_exp(5'b00001, 1'b0);
    push_exp(5'b00001, 1'b0);
    wait_done("b2b_first", n);
    wait_done("b2b_second", n);
    start = 1'b0;
    if (n >= 0) check("b2b_gap", n, 7);
    repeat (10) @(negedge clock);
    check("b2b_idle_busy", busy, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
